// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus definitions.
//   SUB_A1..SUB_X3 : 3-bit subcycle codes of the 8-subcycle instruction cycle
//   OPA_WRR/OPA_RDR: OPA nibbles of the ROM-port write/read instructions
//   mcs4_cmd_t     : per-cycle command the host presents to the bus master
//   addr_nibble()  : which address nibble goes on the bus in A1/A2/A3
package mcs4_pkg;

    localparam logic [2:0] SUB_A1 = 3'd0;
    localparam logic [2:0] SUB_A2 = 3'd1;
    localparam logic [2:0] SUB_A3 = 3'd2;
    localparam logic [2:0] SUB_M1 = 3'd3;
    localparam logic [2:0] SUB_M2 = 3'd4;
    localparam logic [2:0] SUB_X1 = 3'd5;
    localparam logic [2:0] SUB_X2 = 3'd6;
    localparam logic [2:0] SUB_X3 = 3'd7;

    // OPA of the 0xE_ I/O group: WRR = 0xE2, RDR = 0xEA
    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

    typedef struct packed {
        logic [11:0] pc;
        logic        cm_m2;
        logic        cm_x2;
        logic        wr;
        logic [3:0]  wdata;
    } mcs4_cmd_t;

    // Low nibble first: A1 carries pc[3:0], A3 carries the chip-select nibble.
    function automatic logic [3:0] addr_nibble(input logic [11:0] a, input logic [2:0] s);
        case (s)
            SUB_A1:  return a[3:0];
            SUB_A2:  return a[7:4];
            SUB_A3:  return a[11:8];
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/mcs4_bus_master_if.sv
// MCS-4 bus pins as seen between the CPU-side master and i4001/i4002 responders.
//   clk1_pad/clk2_pad : two-phase clocks
//   sync_pad          : high for the X3 subcycle
//   cmrom_pad         : command ROM line(s)
//   data_out/data_dir : master drive value and enable (the tri-state pad is outside)
//   data_pad          : resolved bus value returned to the master
interface mcs4_bus_master_if #(
    parameter int CM_LINES = 1
);
    logic                clk1_pad;
    logic                clk2_pad;
    logic                sync_pad;
    logic [CM_LINES-1:0] cmrom_pad;
    logic [3:0]          data_out;
    logic                data_dir;
    logic [3:0]          data_pad;

    modport master (
        output clk1_pad, clk2_pad, sync_pad, cmrom_pad, data_out, data_dir,
        input  data_pad
    );

    modport slave (
        input  clk1_pad, clk2_pad, sync_pad, cmrom_pad, data_out, data_dir,
        output data_pad
    );
endinterface

// File: rtl/mcs4_phase_gen.sv
// Subcycle timebase for the MCS-4 master.
//   sysclk, poc       : clock and synchronous active-high clear
//   tick, sub         : current tick within subcycle and current subcycle
//   tick_nxt, sub_nxt : values they take at the next edge, so the parent can
//                       register its own outputs aligned with tick/sub
//   clk1, clk2, sync  : registered phase clocks and sync
// TICKS must be a multiple of 4 and at least 4.
module mcs4_phase_gen
    import mcs4_pkg::*;
#(
    parameter int TICKS = 8
) (
    input  logic                       sysclk,
    input  logic                       poc,
    output logic [$clog2(TICKS)-1:0]   tick,
    output logic [2:0]                 sub,
    output logic [$clog2(TICKS)-1:0]   tick_nxt,
    output logic [2:0]                 sub_nxt,
    output logic                       clk1,
    output logic                       clk2,
    output logic                       sync
);
    localparam int TW = $clog2(TICKS);
    localparam int Q  = TICKS / 4;
    localparam logic [TW-1:0] T_LAST  = TW'(TICKS - 1);
    localparam logic [TW-1:0] C1_END  = TW'(Q);
    localparam logic [TW-1:0] C2_BEG  = TW'(2 * Q);
    localparam logic [TW-1:0] C2_END  = TW'(3 * Q);

    // Low for the first edge after poc: that edge holds tick 0 of X3 so the
    // restart shows a full X3 with sync high before A1.
    logic running;

    always_comb begin
        tick_nxt = '0;
        sub_nxt  = SUB_X3;
        if (running) begin
            if (tick == T_LAST) begin
                tick_nxt = '0;
                sub_nxt  = sub + 3'd1;
            end else begin
                tick_nxt = tick + TW'(1);
                sub_nxt  = sub;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (poc) begin
            running <= 1'b0;
            tick    <= '0;
            sub     <= SUB_X3;
            clk1    <= 1'b0;
            clk2    <= 1'b0;
            sync    <= 1'b0;
        end else begin
            running <= 1'b1;
            tick    <= tick_nxt;
            sub     <= sub_nxt;
            clk1    <= (tick_nxt < C1_END);
            clk2    <= (tick_nxt >= C2_BEG) && (tick_nxt < C2_END);
            sync    <= (sub_nxt == SUB_X3);
        end
    end

endmodule

// File: rtl/mcs4_bus_master.sv
// CPU-side MCS-4 bus initiator.
//   sysclk, poc          : clock and synchronous active-high power-on clear
//   bus (master modport) : clk1/clk2/sync/cmrom generation, data drive/sample
//   pc, pc_ack           : next fetch address; pc_ack marks the latch tick
//   inst, inst_valid     : fetched {OPR,OPA} and its one-tick strobe
//   io_cm_m2, io_cm_x2   : CMROM in M2 / X2 of the next cycle
//   io_wr, io_wdata      : drive io_wdata in X2 of the next cycle
//   io_rdata, io_rvalid  : X2 sample when not writing, and its strobe
//   sub                  : current subcycle (0=A1 .. 7=X3)
// Every output is a flop; bus-side values are computed from the phase
// generator's next-state so they line up with tick/sub.
module mcs4_bus_master
    import mcs4_pkg::*;
#(
    parameter int TICKS    = 8,
    parameter int CM_LINES = 1
) (
    input  logic                sysclk,
    input  logic                poc,
    mcs4_bus_master_if.master   bus,
    input  logic [11:0]         pc,
    output logic                pc_ack,
    output logic [7:0]          inst,
    output logic                inst_valid,
    input  logic                io_cm_m2,
    input  logic                io_cm_x2,
    input  logic                io_wr,
    input  logic [3:0]          io_wdata,
    output logic [3:0]          io_rdata,
    output logic                io_rvalid,
    output logic [2:0]          sub
);
    localparam int TW = $clog2(TICKS);
    localparam int Q  = TICKS / 4;
    localparam logic [TW-1:0] T_LAST = TW'(TICKS - 1);
    // Last tick with clk2 high: responders have had the whole clk2 phase to settle.
    localparam logic [TW-1:0] T_CAP  = TW'(3 * Q - 1);

    logic [TW-1:0] tick, tick_nxt;
    logic [2:0]    sub_q, sub_nxt;
    logic          clk1, clk2, sync;

    mcs4_phase_gen #(.TICKS(TICKS)) u_phase (
        .sysclk   (sysclk),
        .poc      (poc),
        .tick     (tick),
        .sub      (sub_q),
        .tick_nxt (tick_nxt),
        .sub_nxt  (sub_nxt),
        .clk1     (clk1),
        .clk2     (clk2),
        .sync     (sync)
    );

    assign sub          = sub_q;
    assign bus.clk1_pad = clk1;
    assign bus.clk2_pad = clk2;
    assign bus.sync_pad = sync;

    mcs4_cmd_t cmd_host, cmd_l, cmd_nxt;
    logic      latch_now, cap_now;

    assign cmd_host  = '{pc: pc, cm_m2: io_cm_m2, cm_x2: io_cm_x2, wr: io_wr, wdata: io_wdata};
    assign latch_now = (sub_q == SUB_X3) && (tick == T_LAST);
    assign cap_now   = (tick == T_CAP);
    // On the latch edge the A1 drive must already see the new pc.
    assign cmd_nxt   = latch_now ? cmd_host : cmd_l;

    logic       dir_nxt, cm0_nxt;
    logic [3:0] dout_nxt;

    always_comb begin
        dir_nxt  = 1'b0;
        dout_nxt = 4'h0;
        cm0_nxt  = 1'b0;
        case (sub_nxt)
            SUB_A1, SUB_A2: begin
                dir_nxt  = 1'b1;
                dout_nxt = addr_nibble(cmd_nxt.pc, sub_nxt);
            end
            SUB_A3: begin
                dir_nxt  = 1'b1;
                dout_nxt = addr_nibble(cmd_nxt.pc, sub_nxt);
                cm0_nxt  = 1'b1;
            end
            SUB_M2: cm0_nxt = cmd_nxt.cm_m2;
            SUB_X2: begin
                cm0_nxt = cmd_nxt.cm_x2;
                if (cmd_nxt.wr) begin
                    dir_nxt  = 1'b1;
                    dout_nxt = cmd_nxt.wdata;
                end
            end
            default: ;
        endcase
    end

    logic [3:0] opr;

    always_ff @(posedge sysclk) begin
        if (poc) begin
            cmd_l         <= '0;
            opr           <= 4'h0;
            pc_ack        <= 1'b0;
            inst          <= 8'h00;
            inst_valid    <= 1'b0;
            io_rdata      <= 4'h0;
            io_rvalid     <= 1'b0;
            bus.data_dir  <= 1'b0;
            bus.data_out  <= 4'h0;
            bus.cmrom_pad <= '0;
        end else begin
            if (latch_now)
                cmd_l <= cmd_host;
            pc_ack        <= (sub_nxt == SUB_X3) && (tick_nxt == T_LAST);
            bus.data_dir  <= dir_nxt;
            bus.data_out  <= dout_nxt;
            bus.cmrom_pad <= CM_LINES'(cm0_nxt);

            inst_valid <= 1'b0;
            io_rvalid  <= 1'b0;
            if (cap_now && sub_q == SUB_M1)
                opr <= bus.data_pad;
            if (cap_now && sub_q == SUB_M2) begin
                inst       <= {opr, bus.data_pad};
                inst_valid <= 1'b1;
            end
            if (cap_now && sub_q == SUB_X2 && !cmd_l.wr) begin
                io_rdata  <= bus.data_pad;
                io_rvalid <= 1'b1;
            end
        end
    end

endmodule
